// File: rtl/ifetch_queue_if.sv
// Fetch-queue bus: instruction-cache request/response, execute-stage redirect
// and the decode-side valid/ready handshake.
interface ifetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) ();
  logic [XLEN-1:0]              INS_ADDR;
  logic                         INS_READ_EN;
  logic                         INS_CACHE_BUSY_WAIT;
  logic [XLEN-1:0]              INSTRUCTION;
  logic                         REDIRECT_EN;
  logic [XLEN-1:0]              REDIRECT_PC;
  logic                         DEC_VALID;
  logic                         DEC_READY;
  logic [XLEN-1:0]              DEC_PC;
  logic [XLEN-1:0]              DEC_INSTRUCTION;
  logic [$clog2(DEPTH+1)-1:0]   COUNT;

  modport master (
    output INS_ADDR, INS_READ_EN, DEC_VALID, DEC_PC, DEC_INSTRUCTION, COUNT,
    input  INS_CACHE_BUSY_WAIT, INSTRUCTION, REDIRECT_EN, REDIRECT_PC, DEC_READY
  );

  modport slave (
    input  INS_ADDR, INS_READ_EN, DEC_VALID, DEC_PC, DEC_INSTRUCTION, COUNT,
    output INS_CACHE_BUSY_WAIT, INSTRUCTION, REDIRECT_EN, REDIRECT_PC, DEC_READY
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: DEPTH-entry prefetch queue of {PC, instruction}
// pairs between the instruction cache and decode, flushed in one cycle on redirect.
module ifetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic           CLK,
  input  logic           RESET,
  ifetch_queue_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [2*XLEN-1:0] mem_q [DEPTH];
  logic [2*XLEN-1:0] mem_d [DEPTH];

  logic read_en;
  logic push;
  logic pop;

  // Redirect outranks everything; the full check uses the pre-edge count, so
  // a pop while full never lets a push through in the same cycle.
  always_comb begin
    read_en = (count_q != FULL) && !bus.REDIRECT_EN && !RESET;
    push    = read_en && !bus.INS_CACHE_BUSY_WAIT;
    pop     = (count_q != '0) && bus.DEC_READY && !bus.REDIRECT_EN;

    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;

    if (bus.REDIRECT_EN) begin
      pc_d    = {bus.REDIRECT_PC[XLEN-1:2], 2'b00};
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = {pc_q, bus.INSTRUCTION};
        tail_d        = tail_q + PTR_W'(1);
        pc_d          = pc_q + XLEN'(4);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is deliberately unreset; only pointers and count define validity.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  always_comb begin
    bus.INS_ADDR        = pc_q;
    bus.INS_READ_EN     = read_en;
    bus.COUNT           = count_q;
    bus.DEC_VALID       = (count_q != '0);
    bus.DEC_PC          = '0;
    bus.DEC_INSTRUCTION = '0;
    if (count_q != '0) begin
      bus.DEC_PC          = mem_q[head_q][2*XLEN-1:XLEN];
      bus.DEC_INSTRUCTION = mem_q[head_q][XLEN-1:0];
    end
  end

endmodule
